// File: rtl/tlp_fifo_pkg.sv
// Shared types and helpers for the TLP store-and-forward packet FIFO.
package tlp_fifo_pkg;

  localparam int unsigned DROP_CNT_W = 16;

  typedef enum logic {
    InAccept,
    InDrop
  } in_state_e;

  typedef enum logic {
    OutIdle,
    OutStream
  } out_state_e;

  // Stored word layout is {tlast, tkeep, tdata}.
  function automatic int unsigned ram_word_w(int unsigned data_w);
    return data_w + data_w / 8 + 1;
  endfunction

endpackage

// File: rtl/tlp_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
module tlp_fifo_ram #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 512,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read register only updates on re_i, so the output holds while the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tlp_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO feeding the PCIe core TX port.
// Packets are released only once fully buffered; oversize packets are dropped and counted.
module tlp_pkt_fifo
  import tlp_fifo_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned DEPTH_LOG2    = 9,
  parameter int unsigned MAX_PKT_WORDS = 64,
  parameter int unsigned BUF_AV_MIN    = 1
) (
  input  logic                  user_clk,
  input  logic                  user_reset,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic [DATA_W/8-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic [5:0]            tx_buf_av,
  output logic [DEPTH_LOG2:0]   stat_pkt_count,
  output logic [DEPTH_LOG2:0]   stat_level,
  output logic [DROP_CNT_W-1:0] stat_drop_count
);

  localparam int unsigned PtrW  = DEPTH_LOG2 + 1;
  localparam int unsigned WordW = ram_word_w(DATA_W);
  localparam int unsigned LenW  = $clog2(MAX_PKT_WORDS + 1);

  localparam logic [PtrW-1:0]       PtrOne   = PtrW'(1);
  localparam logic [LenW-1:0]       LenOne   = LenW'(1);
  localparam logic [LenW-1:0]       LenLast  = LenW'(MAX_PKT_WORDS - 1);
  localparam logic [5:0]            BufAvMin = 6'(BUF_AV_MIN);
  localparam logic [DROP_CNT_W-1:0] DropMax  = '1;

  in_state_e             in_state_q, in_state_d;
  out_state_e            out_state_q, out_state_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       wr_commit_q, wr_commit_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       pkt_count_q, pkt_count_d;
  logic [LenW-1:0]       len_q, len_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  rst_hold_q;

  logic             full, in_hs, out_hs, wr_en, rd_en, commit, rd_last, gate_open;
  logic [WordW-1:0] rd_word;

  // rd_ptr is the next RAM address to fetch; the fetched word sits in the RAM read register.
  assign full = (wr_ptr_q == {~rd_ptr_q[PtrW-1], rd_ptr_q[PtrW-2:0]});

  assign s_axis_tready = !user_reset && !rst_hold_q && ((in_state_q == InDrop) || !full);
  assign in_hs         = s_axis_tvalid && s_axis_tready;

  assign m_axis_tvalid = !user_reset && (out_state_q == OutStream);
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = rd_word;
  assign out_hs        = m_axis_tvalid && m_axis_tready;
  assign rd_last       = out_hs && m_axis_tlast;
  assign gate_open     = (tx_buf_av >= BufAvMin);

  assign stat_pkt_count  = pkt_count_q;
  assign stat_level      = wr_ptr_q - rd_ptr_q;
  assign stat_drop_count = drop_cnt_q;

  tlp_fifo_ram #(
    .Width (WordW),
    .Depth (2 ** DEPTH_LOG2)
  ) u_ram (
    .clk_i   (user_clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[PtrW-2:0]),
    .wdata_i ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q[PtrW-2:0]),
    .rdata_o (rd_word)
  );

  // Input FSM: write words, commit on tlast, rewind and discard packets that grow too long.
  always_comb begin
    in_state_d  = in_state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    len_d       = len_q;
    drop_cnt_d  = drop_cnt_q;
    wr_en       = 1'b0;
    commit      = 1'b0;
    if (in_hs) begin
      unique case (in_state_q)
        InAccept: begin
          wr_en = 1'b1;
          if (s_axis_tlast) begin
            commit      = 1'b1;
            wr_ptr_d    = wr_ptr_q + PtrOne;
            wr_commit_d = wr_ptr_q + PtrOne;
            len_d       = '0;
          end else if (len_q == LenLast) begin
            // Non-last word at the size limit: abandon everything since the last commit.
            wr_ptr_d   = wr_commit_q;
            len_d      = len_q + LenOne;
            in_state_d = InDrop;
          end else begin
            wr_ptr_d = wr_ptr_q + PtrOne;
            len_d    = len_q + LenOne;
          end
        end
        InDrop: begin
          if (s_axis_tlast) begin
            if (drop_cnt_q != DropMax) drop_cnt_d = drop_cnt_q + 1'b1;
            len_d      = '0;
            in_state_d = InAccept;
          end
        end
        default: ;
      endcase
    end
  end

  // Output FSM: fetch one word ahead, only from committed packets, gated by tx_buf_av.
  always_comb begin
    out_state_d = out_state_q;
    rd_ptr_d    = rd_ptr_q;
    rd_en       = 1'b0;
    pkt_count_d = pkt_count_q;
    unique case (out_state_q)
      OutIdle: begin
        if ((pkt_count_q != '0) && gate_open) begin
          rd_en       = 1'b1;
          rd_ptr_d    = rd_ptr_q + PtrOne;
          out_state_d = OutStream;
        end
      end
      OutStream: begin
        if (out_hs) begin
          // Mid-packet, or another whole packet already waiting with the gate open.
          if (!m_axis_tlast || ((pkt_count_q > PtrOne) && gate_open)) begin
            rd_en    = 1'b1;
            rd_ptr_d = rd_ptr_q + PtrOne;
          end else begin
            out_state_d = OutIdle;
          end
        end
      end
      default: ;
    endcase
    unique case ({commit, rd_last})
      2'b10:   pkt_count_d = pkt_count_q + PtrOne;
      2'b01:   pkt_count_d = pkt_count_q - PtrOne;
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  // State registers; rst_hold_q keeps the input closed for one cycle after reset.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      in_state_q  <= InAccept;
      out_state_q <= OutIdle;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      pkt_count_q <= '0;
      len_q       <= '0;
      drop_cnt_q  <= '0;
      rst_hold_q  <= 1'b1;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_count_q <= pkt_count_d;
      len_q       <= len_d;
      drop_cnt_q  <= drop_cnt_d;
      rst_hold_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tlp_pkt_fifo.sv
// Bench for tlp_pkt_fifo: packet-level queue model plus directed scenarios and random traffic.
module tb_tlp_pkt_fifo;

  localparam int MAXW = 64;

  logic        user_clk = 1'b0;
  logic        user_reset = 1'b1;
  logic [31:0] s_axis_tdata = '0;
  logic [3:0]  s_axis_tkeep = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [5:0]  tx_buf_av = 6'd8;
  logic [9:0]  stat_pkt_count;
  logic [9:0]  stat_level;
  logic [15:0] stat_drop_count;

  int n_checks = 0;
  int n_errors = 0;

  // Model: words of committed packets awaiting output, the packet being received, counters.
  logic [36:0] out_q[$];
  logic [36:0] cur_q[$];
  int          pkts = 0;
  bit          dropping = 1'b0;
  int          drops = 0;
  int          words_out = 0;
  int          rdy_mode = 0;

  always #5 user_clk = ~user_clk;

  tlp_pkt_fifo #(
    .DATA_W        (32),
    .DEPTH_LOG2    (9),
    .MAX_PKT_WORDS (MAXW),
    .BUF_AV_MIN    (1)
  ) dut (
    .user_clk        (user_clk),
    .user_reset      (user_reset),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .tx_buf_av       (tx_buf_av),
    .stat_pkt_count  (stat_pkt_count),
    .stat_level      (stat_level),
    .stat_drop_count (stat_drop_count)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge user_clk);
  endtask

  // Sink-ready pattern: 0 always ready, 1 never ready, 2 random.
  initial forever begin
    @(negedge user_clk);
    m_axis_tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
  end

  // Compare process: runs every cycle after the inputs have settled.
  initial begin : cmp
    logic [36:0] mword, iword;
    bit          prev_rst, expect_valid, stall_prev, gate_prev;
    logic [36:0] stall_word;
    int          wait_cnt;
    prev_rst = 1'b1; expect_valid = 1'b0; stall_prev = 1'b0; gate_prev = 1'b0; wait_cnt = 0;
    stall_word = '0;
    forever begin
      @(negedge user_clk);
      #2;
      mword = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (user_reset) begin
        check("rst_tready", s_axis_tready, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        out_q.delete(); cur_q.delete();
        pkts = 0; dropping = 1'b0; drops = 0;
        expect_valid = 1'b0; stall_prev = 1'b0; gate_prev = 1'b0; wait_cnt = 0;
        prev_rst = 1'b1;
      end else begin
        if (prev_rst) begin
          check("post_rst_tready", s_axis_tready, 0);
          check("post_rst_tvalid", m_axis_tvalid, 0);
        end
        check("pkt_count", stat_pkt_count, pkts);
        check("drop_count", stat_drop_count, drops);
        if (dropping) check("drop_tready", s_axis_tready, 1);
        if (expect_valid) check("no_gap", m_axis_tvalid, 1);
        if (stall_prev) check("axi_stable", mword, stall_word);
        if (m_axis_tvalid) begin
          check("out_pending", out_q.size() != 0, 1);
          if (out_q.size() != 0) check("out_word", mword, out_q[0]);
          if (!expect_valid) begin
            check("start_gate", gate_prev, 1);
            check("start_latency", wait_cnt <= 2, 1);
          end
          wait_cnt = 0;
        end else if (pkts > 0 && tx_buf_av >= 6'd1) begin
          wait_cnt++;
          if (wait_cnt == 3) check("latency_expired", m_axis_tvalid, 1);
        end else begin
          wait_cnt = 0;
        end
        stall_prev   = m_axis_tvalid && !m_axis_tready;
        stall_word   = mword;
        expect_valid = m_axis_tvalid && !(m_axis_tready && m_axis_tlast);
        gate_prev    = (tx_buf_av >= 6'd1);
        if (m_axis_tvalid && m_axis_tready && out_q.size() != 0) begin
          if (out_q[0][36]) pkts--;
          void'(out_q.pop_front());
          words_out++;
        end
        if (s_axis_tvalid && s_axis_tready) begin
          iword = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
          if (!dropping) begin
            cur_q.push_back(iword);
            if (s_axis_tlast) begin
              foreach (cur_q[k]) out_q.push_back(cur_q[k]);
              cur_q.delete();
              pkts++;
            end else if (cur_q.size() == MAXW) begin
              cur_q.delete();
              dropping = 1'b1;
            end
          end else if (s_axis_tlast) begin
            dropping = 1'b0;
            if (drops < 65535) drops++;
          end
        end
        prev_rst = 1'b0;
      end
    end
  end

  task automatic send_pkt(input int len, input int stall_after, input int stall_len,
                          input bit gaps);
    for (int i = 0; i < len; i++) begin
      bit acc;
      int guard;
      acc = 1'b0;
      guard = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = $urandom;
      s_axis_tkeep  = 4'($urandom);
      s_axis_tlast  = (i == len - 1);
      while (!acc && guard < 3000) begin
        #1 acc = s_axis_tready;
        @(negedge user_clk);
        guard++;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (!acc) begin
        check("send_accept", acc, 1);
        return;
      end
      if (stall_len > 0 && i == stall_after) begin
        tick(3);
        check("stall_no_valid", m_axis_tvalid, 0);
        tick(stall_len - 3);
      end
      if (gaps && $urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((out_q.size() != 0 || m_axis_tvalid) && guard < 5000) begin
      tick(1);
      guard++;
    end
    check("drain_done", out_q.size(), 0);
    tick(2);
  endtask

  initial begin : stim
    int base;
    @(negedge user_clk);
    tick(2);
    check("reset_level", stat_level, 0);
    check("reset_pkts", stat_pkt_count, 0);
    user_reset = 1'b0;
    tick(2);

    // 1: single 4-word packet, gate open, sink always ready.
    rdy_mode = 0;
    tx_buf_av = 6'd8;
    base = words_out;
    send_pkt(4, -1, 0, 1'b0);
    check("t1_pkt_committed", stat_pkt_count, 1);
    wait_drain();
    check("t1_words", words_out - base, 4);
    check("t1_pkts_after", stat_pkt_count, 0);
    check("t1_level", stat_level, 0);

    // 2: input stalls mid-packet; nothing may leave before tlast.
    base = words_out;
    send_pkt(6, 2, 5, 1'b0);
    wait_drain();
    check("t2_words", words_out - base, 6);

    // 3: oversize packet dropped, then a short one and an exactly-maximum one.
    base = words_out;
    send_pkt(65, -1, 0, 1'b0);
    tick(2);
    check("t3_level_after_drop", stat_level, 0);
    check("t3_drops", stat_drop_count, 1);
    send_pkt(2, -1, 0, 1'b0);
    wait_drain();
    check("t3_words", words_out - base, 2);
    base = words_out;
    send_pkt(MAXW, -1, 0, 1'b0);
    wait_drain();
    check("t3_max_words", words_out - base, MAXW);
    check("t3_drops_kept", stat_drop_count, 1);

    // 4: gate closed holds committed packets back.
    tx_buf_av = 6'd0;
    base = words_out;
    send_pkt(3, -1, 0, 1'b0);
    send_pkt(5, -1, 0, 1'b0);
    tick(10);
    check("t4_no_valid", m_axis_tvalid, 0);
    check("t4_pkts", stat_pkt_count, 2);
    check("t4_level", stat_level, 8);
    tx_buf_av = 6'd1;
    wait_drain();
    check("t4_words", words_out - base, 8);

    // 5: fill to capacity, then drain with a random sink across the pointer wrap.
    tx_buf_av = 6'd0;
    rdy_mode = 1;
    base = words_out;
    for (int p = 0; p < 8; p++) send_pkt(MAXW, -1, 0, 1'b0);
    tick(1);
    check("t5_full_tready", s_axis_tready, 0);
    check("t5_full_level", stat_level, 512);
    check("t5_full_pkts", stat_pkt_count, 8);
    tx_buf_av = 6'd8;
    rdy_mode = 2;
    wait_drain();
    check("t5_words", words_out - base, 512);
    check("t5_level", stat_level, 0);

    // Random traffic: lengths straddle the size limit, random gaps, sink and gate.
    for (int p = 0; p < 30; p++) begin
      if ((out_q.size() + cur_q.size()) < 300 && $urandom_range(0, 3) == 0) tx_buf_av = 6'd0;
      else tx_buf_av = 6'($urandom_range(1, 63));
      send_pkt($urandom_range(1, 70), -1, 0, 1'b1);
    end
    tx_buf_av = 6'd8;
    wait_drain();
    check("rand_level", stat_level, 0);

    // 6: reset in the middle of an outgoing packet.
    rdy_mode = 2;
    send_pkt(12, -1, 0, 1'b0);
    begin
      int guard;
      guard = 0;
      while (!m_axis_tvalid && guard < 100) begin
        tick(1);
        guard++;
      end
      check("t6_started", m_axis_tvalid, 1);
    end
    tick(2);
    user_reset = 1'b1;
    tick(1);
    check("t6_valid_low", m_axis_tvalid, 0);
    user_reset = 1'b0;
    tick(1);
    check("t6_pkts", stat_pkt_count, 0);
    check("t6_level", stat_level, 0);
    check("t6_drops", stat_drop_count, 0);
    tick(1);
    base = words_out;
    send_pkt(3, -1, 0, 1'b0);
    wait_drain();
    check("t6_words", words_out - base, 3);
    check("t6_pkts_after", stat_pkt_count, 0);

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
